cpu_mem_access: RTL and testbench

//  MEM-stage data-memory access unit, directly downstream of the EX stage. Takes EX's memory request (ce/we/addr/sel/wdata)

---
 rtl/cpu_mem_access_if.sv | 14 +
 rtl/cpu_mem_access.sv | 128 ++++++++++++
 tb/tb_cpu_mem_access.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_access_if.sv
// cpu_mem_access_if: data-bus request/acknowledge bundle between the MEM stage and data memory
//   master (MEM stage): drives bus_req, bus_we, bus_addr, bus_be, bus_wdata; samples bus_ack, bus_rdata
//   slave  (memory)   : samples the request; drives bus_ack with bus_rdata valid in the same cycle
interface cpu_mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ack, bus_rdata);
  modport slave (input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/cpu_mem_access.sv
// cpu_mem_access: MEM-stage data-memory access unit (one req/ack transaction per access, load alignment)
//   clk, rst        clock, asynchronous active-high reset
//   i_flush/i_hold  pipeline flush, MEM-stage hold
//   i_req_*         memory request from EX/MEM (valid, we, addr, sel, wdata)
//   i_load_op       0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LW
//   i_reg2_old      old rt value for LWL/LWR merge
//   bus             data-bus master port
//   o_stall_req     combinational pipeline stall
//   o_load_data     aligned load result, valid while o_done
//   o_done          transaction finished, result presented
//   o_bus_error     watchdog expired, valid while o_done
module cpu_mem_access #(
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_req_valid,
  input  logic             i_req_we,
  input  logic [31:0]      i_req_addr,
  input  logic [3:0]       i_req_sel,
  input  logic [31:0]      i_req_wdata,
  input  logic [2:0]       i_load_op,
  input  logic [31:0]      i_reg2_old,
  cpu_mem_access_if.master bus,
  output logic             o_stall_req,
  output logic [31:0]      o_load_data,
  output logic             o_done,
  output logic             o_bus_error
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_wd;
  logic          r_drop, r_bus_req, r_bus_we, r_bus_error;
  logic [31:0]   r_bus_addr, r_bus_wdata, r_load_data, r_old;
  logic [3:0]    r_bus_be;
  logic [1:0]    r_a;
  logic [2:0]    r_op;
  logic          w_start, w_to, w_end, w_drop;
  logic [4:0]    w_sh, w_shl;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rd, w_lwl, w_lwr, w_ld;
  // A flush arriving with the ack still discards the result, hence w_drop folds in i_flush.
  always_comb begin
    w_start = r_state == IDLE && i_req_valid && !i_flush;
    w_to = TIMEOUT != 0 && r_wd == WD_LAST;
    w_end = r_state == BUSY && (bus.bus_ack || w_to);
    w_drop = r_drop || i_flush;
    w_state_nx = r_state == IDLE ? (w_start ? BUSY : IDLE)
               : r_state == BUSY ? (w_end ? (w_drop ? IDLE : DONE) : BUSY)
               : (i_flush || !i_hold) ? IDLE : DONE;
  end
  // LWL keeps the low (3-a) old bytes under the shifted-up read word; LWR keeps the high a old bytes.
  always_comb begin
    w_rd = bus.bus_rdata;
    w_sh = {r_a, 3'b000};
    w_shl = {~r_a, 3'b000};
    w_byte = w_rd[w_sh +: 8];
    w_half = r_a[1] ? w_rd[31:16] : w_rd[15:0];
    w_lwl = (w_rd << w_shl) | (r_old & ~(32'hFFFF_FFFF << w_shl));
    w_lwr = (w_rd >> w_sh) | (r_old & ~(32'hFFFF_FFFF >> w_sh));
    w_ld = r_op == 3'd1 ? {{24{w_byte[7]}}, w_byte}
         : r_op == 3'd2 ? {24'h0, w_byte}
         : r_op == 3'd3 ? {{16{w_half[15]}}, w_half}
         : r_op == 3'd4 ? {16'h0, w_half}
         : r_op == 3'd5 ? w_lwl
         : r_op == 3'd6 ? w_lwr
         : w_rd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req <= 1'b0;
      r_bus_we <= 1'b0;
      r_bus_addr <= '0;
      r_bus_be <= '0;
      r_bus_wdata <= '0;
      r_load_data <= '0;
      r_bus_error <= 1'b0;
      r_drop <= 1'b0;
      r_wd <= '0;
      r_a <= '0;
      r_op <= '0;
      r_old <= '0;
    end else begin
      if (w_start) begin
        r_bus_req <= 1'b1;
        r_bus_we <= i_req_we;
        r_bus_addr <= {i_req_addr[31:2], 2'b00};
        r_bus_be <= i_req_we ? i_req_sel : 4'hF;
        r_bus_wdata <= i_req_wdata;
        r_a <= i_req_addr[1:0];
        r_op <= i_load_op;
        r_old <= i_reg2_old;
      end
      if (r_state == BUSY) begin
        r_wd <= r_wd + CW'(1);
        if (i_flush) r_drop <= 1'b1;
      end
      if (w_end) begin
        r_bus_req <= 1'b0;
        r_drop <= 1'b0;
        r_wd <= '0;
        if (!w_drop) begin
          r_load_data <= (bus.bus_ack && !r_bus_we) ? w_ld : 32'h0;
          r_bus_error <= !bus.bus_ack;
        end
      end
      if (r_state == DONE && w_state_nx == IDLE) r_bus_error <= 1'b0;
    end
  end
  assign bus.bus_req = r_bus_req;
  assign bus.bus_we = r_bus_we;
  assign bus.bus_addr = r_bus_addr;
  assign bus.bus_be = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;
  assign o_stall_req = r_state == BUSY || w_start;
  assign o_load_data = r_load_data;
  assign o_done = r_state == DONE;
  assign o_bus_error = r_bus_error;
endmodule

// File: tb/tb_cpu_mem_access.sv
// tb_cpu_mem_access: scoreboard bench for cpu_mem_access with a byte-level load reference model
module tb_cpu_mem_access;
  logic        clk = 0, rst = 1, flush = 0, hold = 0, req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, reg2_old = 0;
  logic [3:0]  req_sel = 0;
  logic [2:0]  load_op = 0;
  logic        stall_req, done, bus_error;
  logic [31:0] load_data;
  int          n_cmp = 0, n_bad = 0;
  logic [32:0] exp_res[$];
  logic [68:0] exp_bus[$];
  logic        prev_done = 0, prev_req = 0;
  cpu_mem_access_if bus();
  cpu_mem_access #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_hold(hold), .i_req_valid(req_valid),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_sel(req_sel), .i_req_wdata(req_wdata),
    .i_load_op(load_op), .i_reg2_old(reg2_old), .bus(bus), .o_stall_req(stall_req),
    .o_load_data(load_data), .o_done(done), .o_bus_error(bus_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] a, input logic [31:0] r, input logic [31:0] old);
    logic [7:0] rb[4], ob[4], res[4];
    int ai, h;
    ai = int'(a);
    h = 2 * int'(a[1]);
    for (int i = 0; i < 4; i++) begin
      rb[i] = r[8*i +: 8];
      ob[i] = old[8*i +: 8];
    end
    case (op)
      3'd1: return {{24{rb[ai][7]}}, rb[ai]};
      3'd2: return {24'h0, rb[ai]};
      3'd3: return {{16{rb[h+1][7]}}, rb[h+1], rb[h]};
      3'd4: return {16'h0, rb[h+1], rb[h]};
      3'd5: begin
        for (int i = 0; i < 4; i++) res[i] = (i >= 3 - ai) ? rb[i - (3 - ai)] : ob[i];
        return {res[3], res[2], res[1], res[0]};
      end
      3'd6: begin
        for (int i = 0; i < 4; i++) res[i] = (i <= 3 - ai) ? rb[i + ai] : ob[i];
        return {res[3], res[2], res[1], res[0]};
      end
      default: return r;
    endcase
  endfunction
  function automatic logic [68:0] busv();
    return {bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata};
  endfunction
  function automatic logic [127:0] outs();
    return {23'h0, bus.bus_req, busv(), stall_req, done, bus_error, load_data};
  endfunction
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_res.size() == 0) check("unexpected_done", {127'h0, done}, 128'h0);
      else begin
        logic [32:0] e;
        e = exp_res.pop_front();
        check("load_data", load_data, e[32:1]);
        check("bus_error", bus_error, e[0]);
      end
    end
    if (bus.bus_req && !prev_req) begin
      if (exp_bus.size() == 0) check("unexpected_req", {127'h0, bus.bus_req}, 128'h0);
      else check("bus_request", busv(), exp_bus.pop_front());
    end
    prev_done <= done;
    prev_req <= bus.bus_req;
  end
  task automatic scramble();
    req_valid = 1'($urandom);
    req_we = 1'($urandom);
    load_op = 3'($urandom);
    req_addr = $urandom;
    req_sel = 4'($urandom);
    req_wdata = $urandom;
    reg2_old = $urandom;
  endtask
  // Entered and left just after a rising edge with the DUT idle; dly<0 means the bus never acks.
  task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] wd, input logic [31:0] old, input logic [31:0] rd, input int dly, input int hold_n);
    int st, nb;
    logic stable;
    logic [68:0] snap;
    logic [31:0] ld;
    req_valid = 1; req_we = we; load_op = op; req_addr = addr; req_sel = sel; req_wdata = wd; reg2_old = old;
    exp_bus.push_back({addr[31:2], 2'b00, we, we ? sel : 4'hF, wd});
    exp_res.push_back(dly < 0 ? {32'h0, 1'b1} : {we ? 32'h0 : model(op, addr[1:0], rd, old), 1'b0});
    @(negedge clk);
    st = int'(stall_req);
    @(posedge clk); #1;
    scramble();
    nb = 0;
    stable = 1;
    snap = '0;
    for (int k = 0; k < 20; k++) begin
      if (dly >= 0 && k == dly) begin bus.bus_ack = 1; bus.bus_rdata = rd; end
      @(negedge clk);
      if (!bus.bus_req) break;
      nb++;
      st += int'(stall_req);
      if (k == 0) snap = busv();
      else stable &= (busv() == snap);
      @(posedge clk); #1;
      bus.bus_ack = 0;
      bus.bus_rdata = $urandom;
      scramble();
    end
    req_valid = 0;
    check("busy_cycles", nb, dly < 0 ? 8 : dly + 1);
    check("stall_cycles", st, (dly < 0 ? 8 : dly + 1) + 1);
    check("bus_stable", stable, 1);
    check("done_cycle", {done, stall_req}, 2'b10);
    ld = load_data;
    for (int k = 0; k < hold_n; k++) begin
      hold = 1;
      @(posedge clk); #1;
      scramble();
      req_valid = 0;
      @(negedge clk);
      check("hold_done", {done, load_data}, {1'b1, ld});
    end
    hold = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("leave_done", {done, bus_error, stall_req}, 3'b000);
    @(posedge clk); #1;
  endtask
  task automatic flush_busy(input int fk, input int ak);
    logic [31:0] a;
    a = $urandom;
    req_valid = 1; req_we = 0; load_op = 3'($urandom); req_addr = a; reg2_old = $urandom; req_wdata = $urandom;
    exp_bus.push_back({a[31:2], 2'b00, 1'b0, 4'hF, req_wdata});
    @(posedge clk); #1;
    req_valid = 0;
    for (int c = 1; c <= ak; c++) begin
      flush = (c == fk);
      bus.bus_ack = (c == ak);
      bus.bus_rdata = $urandom;
      @(negedge clk);
      check("flush_busy", {bus.bus_req, stall_req, done}, 3'b110);
      @(posedge clk); #1;
      flush = 0;
      bus.bus_ack = 0;
    end
    @(negedge clk);
    check("flush_end", {bus.bus_req, stall_req, done}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_no_done", {bus.bus_req, done}, 2'b00);
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.bus_ack = 0;
    bus.bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), 128'h0);
    @(posedge clk); #1;
    rst = 0;
    txn(0, 3'd0, 32'h100, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0);
    check("lw_be", bus.bus_be, 4'hF);
    txn(0, 3'd1, 32'h103, 4'h0, 32'h0, 32'h0, 32'h80112233, 0, 0);
    txn(0, 3'd2, 32'h103, 4'h0, 32'h0, 32'h0, 32'h80112233, 1, 0);
    txn(0, 3'd3, 32'h102, 4'h0, 32'h0, 32'h0, 32'h80112233, 0, 1);
    txn(0, 3'd5, 32'h101, 4'h0, 32'h0, 32'h11223344, 32'hAABBCCDD, 2, 0);
    txn(0, 3'd6, 32'h102, 4'h0, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 0);
    txn(1, 3'd0, 32'h200, 4'b0011, 32'h0000BEEF, 32'h0, $urandom, 5, 3);
    txn(0, 3'd0, 32'h300, 4'h0, 32'h0, 32'h0, 32'h5A5A1234, 7, 0);
    flush_busy(2, 5);
    flush_busy(2, 2);
    req_valid = 1; flush = 1; req_addr = 32'h400;
    @(negedge clk);
    check("flush_idle_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    @(negedge clk);
    check("flush_idle_noreq", {bus.bus_req, stall_req}, 2'b00);
    @(posedge clk); #1;
    txn(0, 3'd0, 32'h500, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1, 0);
    req_valid = 1; req_we = 1; req_addr = 32'hFFFF_FFF0; req_sel = 4'hC; req_wdata = 32'h12345678;
    exp_bus.push_back({32'hFFFF_FFF0, 1'b1, 4'hC, 32'h12345678});
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("rst_mid_busy", outs(), 128'h0);
    @(posedge clk); #1;
    rst = 0;
    txn(0, 3'd0, 32'h600, 4'h0, 32'h0, 32'h0, 32'h0, -1, 1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) flush_busy($urandom_range(1, 3), $urandom_range(3, 6));
      else if ($urandom_range(0, 9) == 0) txn(0, 3'($urandom), $urandom, 4'h0, $urandom, $urandom, $urandom, -1, 0);
      else txn(1'($urandom), 3'($urandom), $urandom, 4'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 7), $urandom_range(0, 2));
    end
    @(negedge clk);
    check("queues_drained", exp_res.size() + exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
